// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the UART host-command engine.
package uart_cmd_pkg;

  localparam logic [7:0] OP_READ   = 8'h04;
  localparam logic [7:0] OP_BURST  = 8'h05;
  localparam logic [7:0] OP_RANGE  = 8'h06;
  localparam logic [7:0] OP_WRITE  = 8'h07;
  localparam logic [7:0] OP_TOGGLE = 8'h42;
  localparam logic [7:0] OP_ABORT  = 8'h1B;

  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_START,
    S_GET_COUNT,
    S_GET_WADDR,
    S_GET_WDATA,
    S_RD_WAIT,
    S_SEND,
    S_NEXT
  } state_t;

  // States that wait for another command byte and are guarded by the timeout.
  function automatic logic is_get_state(input state_t s);
    return (s == S_GET_ADDR) || (s == S_GET_START) || (s == S_GET_COUNT) ||
           (s == S_GET_WADDR) || (s == S_GET_WDATA);
  endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Loadable down-counter that flags when a multi-byte command has gone quiet too long.
module cmd_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic kick,
  input  logic stop,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (stop) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start || kick) begin
      run_d = 1'b1;
      cnt_d = CW'(TIMEOUT);
    end else if (run_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Fires on the last allowed silent cycle so the FSM leaves exactly TIMEOUT cycles after the load.
  assign expired = run_q && (cnt_q == CW'(1));

endmodule

// File: rtl/uart_cmd_controller.sv
// Host-command engine: decodes UART opcodes and serves reads, bursts, ranges and writes
// against a byte store, pacing transmit bytes on the transmitter's busy.
module uart_cmd_controller
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter int         DEPTH    = 35,
  parameter int         RD_LAT   = 1,
  parameter int         TIMEOUT  = 1_000_000,
  parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              new_data_rx,
  input  logic [7:0]        data_rx,
  output logic              new_data_tx,
  output logic [7:0]        data_tx,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [7:0]        wr_data,
  output logic              drop,
  output logic              active,
  output logic [7:0]        debug
);

  localparam int               EW        = ADDR_W + 1;
  localparam logic [EW-1:0]    DEPTH_E   = EW'(DEPTH);
  localparam logic [31:0]      DEPTH_W   = 32'(DEPTH);
  localparam logic [1:0]       WAIT_INIT = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [EW-1:0]     end_q, end_d;
  logic [1:0]        wait_q, wait_d;
  logic              err_q, err_d;
  logic              burst_q, burst_d;
  logic              abort_q, abort_d;
  logic              wr_ok_q, wr_ok_d;
  logic              ntx_q, ntx_d;
  logic [7:0]        data_tx_q, data_tx_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              drop_q, drop_d;
  logic              active_q, active_d;
  logic [7:0]        debug_q, debug_d;

  logic              expired;
  logic              is_abort;
  logic              rx_in_range;
  logic [ADDR_W-1:0] load_addr;
  logic [EW-1:0]     addr_e, sum_e, range_end;
  logic              last_byte;

  // Range end is formed one bit wider than the address so start+count never wraps.
  assign load_addr   = ADDR_W'(data_rx);
  assign rx_in_range = ({24'd0, data_rx} < DEPTH_W);
  assign is_abort    = new_data_rx && (data_rx == OP_ABORT);
  assign addr_e      = {1'b0, addr_q};
  assign sum_e       = addr_e + EW'(data_rx);
  assign range_end   = (sum_e > DEPTH_E) ? DEPTH_E : sum_e;
  assign last_byte   = (addr_e + EW'(1)) >= end_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    wait_d    = wait_q;
    err_d     = err_q;
    burst_d   = burst_q;
    abort_d   = abort_q;
    wr_ok_d   = wr_ok_q;
    ntx_d     = 1'b0;
    data_tx_d = data_tx_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    debug_d   = new_data_rx ? data_rx : debug_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (new_data_rx) begin
          case (data_rx)
            OP_READ:  state_d = S_GET_ADDR;
            OP_BURST: begin
              addr_d  = '0;
              end_d   = DEPTH_E;
              burst_d = 1'b1;
              err_d   = 1'b0;
              wait_d  = WAIT_INIT;
              state_d = S_RD_WAIT;
            end
            OP_RANGE:  state_d = S_GET_START;
            OP_WRITE:  state_d = S_GET_WADDR;
            OP_TOGGLE: begin
              drop_d = ~drop_q;
              addr_d = '0;
            end
            default: ;
          endcase
        end
      end
      S_GET_ADDR: begin
        if (new_data_rx) begin
          addr_d  = load_addr;
          end_d   = {1'b0, load_addr} + EW'(1);
          err_d   = ~rx_in_range;
          burst_d = 1'b0;
          wait_d  = WAIT_INIT;
          state_d = S_RD_WAIT;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_GET_START: begin
        if (new_data_rx) begin
          addr_d  = load_addr;
          err_d   = ~rx_in_range;
          state_d = S_GET_COUNT;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_GET_COUNT: begin
        if (new_data_rx) begin
          if ((data_rx == 8'd0) || err_q) begin
            state_d = S_IDLE;
          end else begin
            end_d   = range_end;
            burst_d = 1'b0;
            wait_d  = WAIT_INIT;
            state_d = S_RD_WAIT;
          end
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_GET_WADDR: begin
        if (new_data_rx) begin
          addr_d  = load_addr;
          wr_ok_d = rx_in_range;
          state_d = S_GET_WDATA;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_GET_WDATA: begin
        if (new_data_rx) begin
          wr_data_d = data_rx;
          wr_en_d   = wr_ok_q;
          state_d   = S_IDLE;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (is_abort) abort_d = 1'b1;
        if (wait_q == 2'd0) state_d = S_SEND;
        else                wait_d  = wait_q - 2'd1;
      end
      S_SEND: begin
        if (is_abort) abort_d = 1'b1;
        if (!busy) begin
          data_tx_d = err_q ? ERR_BYTE : rd_data;
          ntx_d     = 1'b1;
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        // An abort seen now or earlier in this byte ends the transfer like a normal last byte.
        if (abort_q || is_abort || last_byte) begin
          state_d = S_IDLE;
          if (burst_q) addr_d = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          wait_d  = WAIT_INIT;
          state_d = S_RD_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      end_q     <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      burst_q   <= 1'b0;
      abort_q   <= 1'b0;
      wr_ok_q   <= 1'b0;
      ntx_q     <= 1'b0;
      data_tx_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
      active_q  <= 1'b0;
      debug_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      end_q     <= end_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      burst_q   <= burst_d;
      abort_q   <= abort_d;
      wr_ok_q   <= wr_ok_d;
      ntx_q     <= ntx_d;
      data_tx_q <= data_tx_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
      active_q  <= active_d;
      debug_q   <= debug_d;
    end
  end

  cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (is_get_state(state_d) && !is_get_state(state_q)),
    .kick    (new_data_rx),
    .stop    (!is_get_state(state_d)),
    .expired (expired)
  );

  assign new_data_tx = ntx_q;
  assign data_tx     = data_tx_q;
  assign addr        = addr_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign drop        = drop_q;
  assign active      = active_q;
  assign debug       = debug_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: a byte-store model, a busy-pacing transmitter model and a
// command-level reference that predicts every transmitted byte and store write.
module tb_uart_cmd_controller;
  import uart_cmd_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 35;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              busy, new_data_rx, new_data_tx, wr_en, drop, active;
  logic [7:0]        data_rx, data_tx, rd_data, wr_data, debug;
  logic [ADDR_W-1:0] addr;

  uart_cmd_controller #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .new_data_rx (new_data_rx),
    .data_rx     (data_rx),
    .new_data_tx (new_data_tx),
    .data_tx     (data_tx),
    .addr        (addr),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .drop        (drop),
    .active      (active),
    .debug       (debug)
  );

  // ---------------- store model (one-cycle read latency) ----------------
  logic [7:0] mem [256];
  logic       store_init;
  always @(posedge clk) begin
    if (store_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (wr_en) begin
      mem[addr] <= wr_data;
    end
    rd_data <= mem[addr];
  end

  // ---------------- transmitter model ----------------
  int busy_len;
  int bcnt;
  initial begin
    busy = 1'b0;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (new_data_tx && busy_len > 0) bcnt = busy_len;
      else if (bcnt > 0)               bcnt--;
      busy = (bcnt > 0);
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0]  mem_m [256];
  logic        drop_m;
  logic [7:0]  debug_m;
  logic [7:0]  exp_q[$];
  logic [15:0] wexp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  int          cyc = 0;
  logic        prev_busy = 1'b0;
  int          n_strobe = 0;
  int          n_wr = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [15:0] last_wr = 16'h0000;
  int          last_strobe_cyc = -1;
  int          gap_min = 1000;
  int          gap_max = 0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_busy <= busy;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (new_data_tx) begin
        n_strobe++;
        last_tx = data_tx;
        if (last_strobe_cyc >= 0) begin
          if (cyc - last_strobe_cyc < gap_min) gap_min = cyc - last_strobe_cyc;
          if (cyc - last_strobe_cyc > gap_max) gap_max = cyc - last_strobe_cyc;
        end
        last_strobe_cyc = cyc;
        check("tx_not_while_busy", prev_busy, 1'b0);
        check("tx_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("tx_data", data_tx, exp_q.pop_front());
      end
      if (wr_en) begin
        n_wr++;
        last_wr = {addr, wr_data};
        check("wr_expected", wexp_q.size() != 0, 1'b1);
        if (wexp_q.size() != 0) check("wr_addr_data", {addr, wr_data}, wexp_q.pop_front());
      end
      check("drop", drop, drop_m);
      check("debug", debug, debug_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    new_data_rx = 1'b1;
    data_rx     = b;
    @(posedge clk);
    #1;
    new_data_rx = 1'b0;
    debug_m     = b;
  endtask

  task automatic gap();
    tick($urandom_range(0, 4));
  endtask

  task automatic cmd_read(input logic [7:0] a);
    exp_q.push_back((int'(a) < DEPTH) ? mem_m[a] : ERR_BYTE_DEFAULT);
    send_byte(OP_READ);
    gap();
    send_byte(a);
  endtask

  task automatic cmd_burst();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(mem_m[a]);
    send_byte(OP_BURST);
  endtask

  task automatic cmd_range(input logic [7:0] s, input logic [7:0] c);
    int e;
    e = int'(s) + int'(c);
    if (e > DEPTH) e = DEPTH;
    for (int a = int'(s); a < e; a++) exp_q.push_back(mem_m[a]);
    send_byte(OP_RANGE);
    gap();
    send_byte(s);
    gap();
    send_byte(c);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    if (int'(a) < DEPTH) begin
      wexp_q.push_back({a, d});
      mem_m[a] = d;
    end
    send_byte(OP_WRITE);
    gap();
    send_byte(a);
    gap();
    send_byte(d);
  endtask

  task automatic cmd_toggle();
    send_byte(OP_TOGGLE);
    drop_m = ~drop_m;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((active || exp_q.size() != 0 || wexp_q.size() != 0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("cmd_done_in_budget", k < budget, 1'b1);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int k;
    k = 0;
    while (n_strobe < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("strobe_wait_in_budget", k < budget, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  int         base, wbase, k, op;
  logic [7:0] j;

  initial begin
    rst         = 1'b1;
    new_data_rx = 1'b0;
    data_rx     = 8'h00;
    store_init  = 1'b1;
    busy_len    = 0;
    drop_m      = 1'b0;
    debug_m     = 8'h00;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
    tick(3);
    check("rst_new_data_tx", new_data_tx, 1'b0);
    check("rst_data_tx", data_tx, 8'h00);
    check("rst_addr", addr, 8'h00);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_drop", drop, 1'b0);
    check("rst_debug", debug, 8'h00);
    check("rst_active", active, 1'b0);
    store_init = 1'b0;
    rst        = 1'b0;
    tick(2);

    // Full burst with a slow transmitter.
    busy_len = 10;
    base = n_strobe;
    cmd_burst();
    wait_idle(2000);
    check("burst_count", n_strobe - base, DEPTH);
    check("burst_last_byte", last_tx, 8'h22);
    check("burst_end_addr", addr, 8'h00);

    // Burst spacing with busy always low.
    busy_len = 0;
    tick(12);
    gap_min = 1000;
    gap_max = 0;
    last_strobe_cyc = -1;
    cmd_burst();
    wait_idle(500);
    check("burst_gap_min", gap_min, 3);
    check("burst_gap_max", gap_max, 3);

    // Writes: in range, then out of range.
    wbase = n_wr;
    cmd_write(8'h03, 8'h5C);
    wait_idle(50);
    check("write_count", n_wr - wbase, 1);
    check("write_lit", last_wr, 16'h035C);
    wbase = n_wr;
    cmd_write(8'h40, 8'h11);
    wait_idle(50);
    tick(2);
    check("write_oob_count", n_wr - wbase, 0);

    // Single read latency and active fall.
    cmd_write(8'h05, 8'hA5);
    wait_idle(50);
    exp_q.push_back(mem_m[5]);
    send_byte(OP_READ);
    send_byte(8'h05);
    k = 0;
    while (!new_data_tx && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("read_latency", k, RD_LAT + 1);
    check("read_data_lit", data_tx, 8'hA5);
    check("read_active_at_strobe", active, 1'b1);
    tick(1);
    check("read_active_fall", active, 1'b0);
    wait_idle(20);

    // Ranged bursts.
    base = n_strobe;
    cmd_range(8'h20, 8'h10);
    wait_idle(200);
    check("range_count", n_strobe - base, 3);
    check("range_last_lit", last_tx, 8'h22);
    base = n_strobe;
    cmd_range(8'h20, 8'h00);
    check("range0_idle", active, 1'b0);
    tick(10);
    check("range0_count", n_strobe - base, 0);
    base = n_strobe;
    cmd_range(8'h30, 8'h05);
    tick(10);
    check("range_oob_count", n_strobe - base, 0);

    // Abort after the fourth burst byte.
    busy_len = 10;
    base = n_strobe;
    for (int a = 0; a < 5; a++) exp_q.push_back(mem_m[a]);
    send_byte(OP_BURST);
    wait_strobes(base + 4, 200);
    send_byte(OP_ABORT);
    wait_idle(200);
    tick(40);
    check("abort_count", n_strobe - base, 5);

    // Out-of-range read returns the error byte.
    busy_len = 0;
    tick(12);
    cmd_read(8'h30);
    wait_idle(50);
    check("read_err_lit", last_tx, 8'hEE);

    // Silence inside a command returns to idle exactly TIMEOUT cycles after the last byte.
    base = n_strobe;
    send_byte(OP_RANGE);
    send_byte(8'h02);
    tick(TIMEOUT - 1);
    check("timeout_still_active", active, 1'b1);
    tick(1);
    check("timeout_idle", active, 1'b0);
    check("timeout_no_tx", n_strobe - base, 0);

    // A byte arriving on the expiry cycle is still accepted.
    wbase = n_wr;
    send_byte(OP_WRITE);
    tick(TIMEOUT - 1);
    wexp_q.push_back(16'h0A3C);
    mem_m[8'h0A] = 8'h3C;
    send_byte(8'h0A);
    send_byte(8'h3C);
    wait_idle(20);
    check("timeout_edge_write", n_wr - wbase, 1);

    // Randomised command mix.
    for (int n = 0; n < 40; n++) begin
      busy_len = $urandom_range(0, 4);
      op = $urandom_range(0, 7);
      case (op)
        0: cmd_read(8'($urandom_range(0, 255)));
        1: cmd_read(8'($urandom_range(0, DEPTH - 1)));
        2: cmd_burst();
        3: cmd_range(8'($urandom_range(0, 40)), 8'($urandom_range(0, 20)));
        4: cmd_range(8'($urandom_range(0, 40)), 8'hFF);
        5: cmd_write(8'($urandom_range(0, 45)), 8'($urandom));
        6: cmd_toggle();
        default: begin
          j = 8'($urandom);
          if (j inside {OP_READ, OP_BURST, OP_RANGE, OP_WRITE, OP_TOGGLE}) j = OP_ABORT;
          send_byte(j);
        end
      endcase
      wait_idle(3000);
      tick($urandom_range(0, 3));
    end

    // Reset in the middle of a burst.
    busy_len = 0;
    tick(6);
    if (!drop_m) cmd_toggle();
    tick(2);
    base = n_strobe;
    cmd_burst();
    wait_strobes(base + 3, 100);
    rst = 1'b1;
    exp_q.delete();
    drop_m  = 1'b0;
    debug_m = 8'h00;
    tick(1);
    check("mid_rst_new_data_tx", new_data_tx, 1'b0);
    check("mid_rst_data_tx", data_tx, 8'h00);
    check("mid_rst_addr", addr, 8'h00);
    check("mid_rst_wr_en", wr_en, 1'b0);
    check("mid_rst_wr_data", wr_data, 8'h00);
    check("mid_rst_drop", drop, 1'b0);
    check("mid_rst_debug", debug, 8'h00);
    check("mid_rst_active", active, 1'b0);
    tick(1);
    rst = 1'b0;
    base = n_strobe;
    tick(200);
    check("post_rst_no_tx", n_strobe - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
